// File: rtl/apb_uart_sink.sv
// APB-attached console sink: THR writes queue bytes in a FIFO drained by a char valid/ready consumer.
// Optional macro APB_UART_SINK_PRINT_EN prints each popped byte to the simulator console.
`timescale 1ns/1ps
module apb_uart_sink #(
    parameter int FifoDepth = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [7:0]  char_o,
    output logic        char_valid_o,
    input  logic        char_ready_i,
    output logic [15:0] drop_cnt_o,
    output logic        empty_o
);

    localparam int AW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FifoDepth);

    localparam logic [7:0] ADDR_THR = 8'h00;
    localparam logic [7:0] ADDR_LSR = 8'h14;
    localparam logic [7:0] ADDR_SCR = 8'h1C;

    logic [7:0]    mem_q [FifoDepth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    scr_q, scr_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic access;
    logic wr_access;
    logic thr_wr;
    logic scr_wr;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;
    logic unused_bits;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign unused_bits = ^{paddr_i[31:8], pwdata_i[31:8]};

    assign access    = psel_i & penable_i;
    assign wr_access = access & pwrite_i;
    assign thr_wr    = wr_access && (paddr_i[7:0] == ADDR_THR);
    assign scr_wr    = wr_access && (paddr_i[7:0] == ADDR_SCR);

    // Full/empty come from the registered count, so a same-cycle pop never frees room for a push.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = thr_wr & ~full;
    assign drop  = thr_wr & full;
    assign pop   = ~empty & char_ready_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        scr_d      = scr_q;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (scr_wr) begin
            scr_d = pwdata_i[7:0];
        end
        if (drop) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            scr_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            scr_q      <= scr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; char_o is masked while empty so it still reads 0 after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wr_ptr_q] <= pwdata_i[7:0];
        end
    end

    always_comb begin
        prdata_o = '0;
        if (psel_i && !pwrite_i) begin
            case (paddr_i[7:0])
                ADDR_LSR: begin
                    prdata_o[5] = ~full;
                    prdata_o[6] = empty;
                end
                ADDR_SCR: prdata_o[7:0] = scr_q;
                default:  prdata_o = '0;
            endcase
        end
    end

    assign pready_o     = access;
    assign pslverr_o    = drop;
    assign char_o       = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign char_valid_o = ~empty;
    assign empty_o      = empty;
    assign drop_cnt_o   = drop_cnt_q;

`ifdef APB_UART_SINK_PRINT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i && pop) begin
            $write("%c", char_o);
        end
    end
`else
`endif

endmodule
